// File: rtl/ram_arbiter_pkg.sv
// Shared encodings and default sizes for the CPU/video RAM arbiter.
package ram_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_BURST_LEN  = 8;
    localparam int DEF_MAX_WAIT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ram_arbiter_burst_sequencer.sv
// Video burst sequencer: address counter, beat counter and last-beat flag.
module ram_arbiter_burst_sequencer
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [BEAT_W-1:0] beat;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr <= '0;
            beat <= '0;
        end else if (load) begin
            addr <= load_addr;
            beat <= '0;
        end else if (advance) begin
            addr <= addr + 1'b1;
            beat <= last ? '0 : beat + 1'b1;
        end
    end

    assign last = (beat == BEAT_W'(BURST_LEN - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between CPU accesses and video read bursts.
// Optional statistics counters are enabled with the ARB_STATS_EN macro.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_start,
    output logic                  vid_rvalid,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    output logic                  vid_done,
`ifdef ARB_STATS_EN
    output logic [15:0]           stat_cpu_wait,
    output logic [15:0]           stat_preempt,
`endif
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    arb_state_t            state_q, state_d;
    owner_t                rd_owner_q, rd_owner_d;
    logic [3:0]            wait_q, wait_d;
    logic                  seq_load, beat_issue, blocked;
    logic [ADDR_WIDTH-1:0] seq_addr;
    logic                  seq_last;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] cpu_hold_q, vid_hold_q;

    ram_arbiter_burst_sequencer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .BURST_LEN (BURST_LEN)
    ) u_seq (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (seq_load),
        .load_addr(vid_addr),
        .advance  (beat_issue),
        .addr     (seq_addr),
        .last     (seq_last)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cpu_gnt    = 1'b0;
        vid_start  = 1'b0;
        seq_load   = 1'b0;
        beat_issue = 1'b0;
        blocked    = 1'b0;
        mem_addr   = '0;
        mem_write  = 1'b0;
        mem_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end else if (vid_req) begin
                    vid_start = 1'b1;
                    seq_load  = 1'b1;
                    state_d   = ST_BURST;
                end
            end
            ST_BURST: begin
                // A CPU blocked for MAX_WAIT cycles steals this beat slot.
                if (cpu_req && wait_q == WAIT_MAX) begin
                    cpu_gnt = 1'b1;
                end else begin
                    beat_issue = 1'b1;
                    blocked    = cpu_req;
                    if (seq_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cpu_gnt = cpu_req;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_write = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (beat_issue) begin
            mem_addr = seq_addr;
        end

        wait_d = '0;
        if (blocked) wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 4'd1;

        rd_owner_d = OWN_NONE;
        if (cpu_gnt && !cpu_we) rd_owner_d = OWN_CPU;
        else if (beat_issue)    rd_owner_d = OWN_VID;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rd_owner_q <= OWN_NONE;
            wait_q     <= '0;
            last_q     <= 1'b0;
            cpu_hold_q <= '0;
            vid_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            wait_q     <= wait_d;
            last_q     <= beat_issue && seq_last;
            if (cpu_rvalid) cpu_hold_q <= mem_rdata;
            if (vid_rvalid) vid_hold_q <= mem_rdata;
        end
    end

    // Return data passes straight through to its owner; the other side keeps its last word.
    assign cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign vid_rvalid = (rd_owner_q == OWN_VID);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold_q;
    assign vid_rdata  = vid_rvalid ? mem_rdata : vid_hold_q;
    assign vid_done   = last_q;

`ifdef ARB_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_cpu_wait <= '0;
            stat_preempt  <= '0;
        end else begin
            if (blocked) stat_cpu_wait <= sat_inc16(stat_cpu_wait);
            if (cpu_gnt && state_q == ST_BURST) stat_preempt <= sat_inc16(stat_preempt);
        end
    end
`endif

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one synchronous single-port CPU RAM (512 x CPU_WIDTH, 1-cycle read latency) between the stack machine's data port and a sprite/video fetch engine.
- The CPU issues single accesses. The video engine issues fixed-length read bursts from a start address.
- The arbiter sequences each burst (address generation, beat count), and a wait counter bounds CPU starvation.
- Sits between StackMachine/sprite engine and the RAM macro in the top level.

Parameters:
DATA_WIDTH, 16, RAM word width (matches CPU_WIDTH)
ADDR_WIDTH, 9, RAM word address width
BURST_LEN, 8, video beats per burst (2..64)
MAX_WAIT, 4, cycles a pending CPU request may be blocked mid-burst before it preempts one beat (1..15)

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
cpu_addr  in  ADDR_WIDTH  CPU word address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_gnt  out  1  access accepted this cycle
cpu_rvalid  out  1  cpu_rdata valid (cycle after a read grant)
cpu_rdata  out  DATA_WIDTH  read data
vid_req  in  1  burst request, held until vid_start
vid_addr  in  ADDR_WIDTH  burst start address, sampled at vid_start
vid_start  out  1  1-cycle pulse: burst accepted
vid_rvalid  out  1  one pulse per returned beat
vid_rdata  out  DATA_WIDTH  beat data
vid_done  out  1  1-cycle pulse with last beat's vid_rvalid
mem_addr  out  ADDR_WIDTH  to RAM
mem_write  out  1  to RAM
mem_wdata  out  DATA_WIDTH  to RAM
mem_rdata  in  DATA_WIDTH  from RAM, registered, 1-cycle latency

Behaviour:
- Reset:
  - State IDLE; burst counter, address counter and wait counter = 0; rd-owner register = NONE.
  - All outputs 0, including mem_addr, mem_write and mem_wdata.
  - Reset mid-burst aborts the burst with no vid_done. In-flight read data is discarded.
- States:
  - IDLE:
    - cpu_req → grant CPU this cycle.
    - Else vid_req → vid_start=1, load addr counter=vid_addr, beat counter=0, go BURST.
    - If both are asserted, CPU wins and video starts the next free cycle.
  - BURST, each cycle:
    - If cpu_req and wait counter == MAX_WAIT: grant CPU, wait counter=0, no video beat this cycle (preempt).
    - Else issue a video read at addr counter. Addr counter +1 wraps mod 2^ADDR_WIDTH. Beat counter +1.
    - If cpu_req was denied this cycle, wait counter +1 (saturating at MAX_WAIT). Otherwise it is 0.
    - After beat BURST_LEN-1 is issued → DRAIN.
  - DRAIN (one cycle): the last beat's data returns here. A CPU grant is allowed this cycle. Next state is IDLE.
- A CPU grant drives mem_addr=cpu_addr, mem_write=cpu_we, mem_wdata=cpu_wdata combinationally in the grant cycle; cpu_gnt=1.
- A video beat drives mem_addr=addr counter, mem_write=0.
- mem_write is never asserted except on a CPU write grant.
- Read return:
  - The rd-owner register records the read issuer (CPU/VID/NONE) each cycle.
  - Next cycle: rvalid=1 for that owner; rdata = mem_rdata. The other rdata output holds its last value.
- vid_done is asserted in the cycle of the BURST_LEN-th vid_rvalid.
- Worst-case CPU latency: MAX_WAIT+1 cycles from cpu_req to cpu_gnt.
- Video throughput is exactly 1 beat/cycle except on preempted cycles.
- vid_req asserted during BURST/DRAIN is ignored until IDLE.
- A CPU write followed immediately by a video read of the same address returns the new data, because RAM writes complete at the edge.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - Extra output ports stat_cpu_wait (16 bit): cumulative CPU-blocked cycles, saturating.
  - stat_preempt (16 bit): preemption count, saturating.
  - Both cleared by reset.
- When undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Shared package/header:
  - State encodings IDLE/BURST/DRAIN.
  - Owner encodings NONE/CPU/VID.
  - Defaults for DATA_WIDTH, ADDR_WIDTH, BURST_LEN.
- One sub-module: burst_sequencer (addr counter, beat counter, last-beat flag).
- Arbitration, wait counter and read-return steering stay in ram_arbiter.

Test Plan:
- CPU write 0x1234 @0x010 then read @0x010, video idle → cpu_gnt both cycles; cpu_rvalid one cycle after the read with cpu_rdata=0x1234.
- RAM preloaded word[i]=i; vid_req with vid_addr=0x1FC, BURST_LEN=8 → vid_start pulse; 8 vid_rvalid beats 0x1FC,0x1FD,0x1FE,0x1FF,0x000..0x003 (wrap); vid_done with the 8th beat.
- cpu_req and vid_req rise the same cycle in IDLE → CPU granted first; vid_start the following cycle.
- cpu_req held from burst beat 1, MAX_WAIT=4 → cpu_gnt exactly 4 cycles after the request; one beat slot skipped; total burst takes 9 issue cycles; beat data remains ordered and correct.
- reset_n asserted at beat 3 → all outputs 0 immediately; no vid_done; after release, a new burst from 0x040 completes normally.
- ARB_STATS_EN build, above preemption scenario → stat_preempt=1, stat_cpu_wait=4.
